// File: rtl/mwmon_pkg.sv
// Shared types for the memory-write self-check monitor.
package mwmon_pkg;

   localparam int unsigned FAIL_CODE_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PASS = 2'd2,
      FAIL = 2'd3
   } state_e;

   typedef enum logic [FAIL_CODE_W-1:0] {
      NONE          = 3'd0,
      UNEXPECTED    = 3'd1,
      DATA_MISMATCH = 3'd2,
      ORDER         = 3'd3,
      DUPLICATE     = 3'd4,
      TIMEOUT       = 3'd5
   } fail_e;

endpackage

// File: rtl/mwmon_match.sv
// Combinational compare of one write against the latched expectation table.
module mwmon_match
   import mwmon_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned NUM_EXP = 4,
   parameter int unsigned CNT_W   = 3,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_EXP*ADDR_W-1:0] exp_adr,
   input  logic [NUM_EXP*DATA_W-1:0] exp_data,
   input  logic [NUM_EXP-1:0]        matched,
   input  logic [CNT_W-1:0]          exp_num,
   input  logic [ADDR_W-1:0]         dataadr,
   input  logic [DATA_W-1:0]         writedata,
   output logic [NUM_EXP-1:0]        adr_hit_c,
   output logic [NUM_EXP-1:0]        data_hit_c,
   output logic [IDX_W-1:0]          low_idx_c,
   output logic                      low_vld_c
);

   logic [NUM_EXP-1:0] cand;

   // Per-entry hits, restricted to the active part of the table.
   for (genvar g = 0; g < NUM_EXP; g++) begin : g_ent
      logic active;
      assign active        = (CNT_W'(g) < exp_num);
      assign adr_hit_c[g]  = active && (dataadr == exp_adr[g*ADDR_W +: ADDR_W]);
      assign data_hit_c[g] = active && (writedata == exp_data[g*DATA_W +: DATA_W]);
   end

   assign cand = adr_hit_c & data_hit_c & ~matched;

   // Lowest unmatched entry hit on both address and data.
   always_comb begin
      low_idx_c = '0;
      low_vld_c = 1'b0;
      for (int i = NUM_EXP - 1; i >= 0; i--) begin
         if (cand[IDX_W'(i)]) begin
            low_idx_c = IDX_W'(i);
            low_vld_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_write_monitor.sv
// Self-check monitor for the CPU data-memory write port.
// Build option: MWMON_CAPTURE_EN captures the offending write into fail_adr/fail_data.
module mem_write_monitor
   import mwmon_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned NUM_EXP        = 4,
   parameter int unsigned ORDERED        = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           clear,
   input  logic [NUM_EXP*ADDR_W-1:0]      exp_adr,
   input  logic [NUM_EXP*DATA_W-1:0]      exp_data,
   input  logic [$clog2(NUM_EXP+1)-1:0]   exp_num,
   input  logic                           allow_en,
   input  logic [ADDR_W-1:0]              allow_adr,
   input  logic                           memwrite,
   input  logic [ADDR_W-1:0]              dataadr,
   input  logic [DATA_W-1:0]              writedata,
   output logic                           busy,
   output logic                           done,
   output logic                           pass,
   output logic [FAIL_CODE_W-1:0]         fail_code,
   output logic [$clog2(NUM_EXP+1)-1:0]   match_cnt,
   output logic [ADDR_W-1:0]              fail_adr,
   output logic [DATA_W-1:0]              fail_data
);

   localparam int unsigned CNT_W   = $clog2(NUM_EXP + 1);
   localparam int unsigned IDX_W   = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
   localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 2);
   localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

   state_e                      state_q, state_d;
   logic [NUM_EXP*ADDR_W-1:0]   exp_adr_q, exp_adr_d;
   logic [NUM_EXP*DATA_W-1:0]   exp_data_q, exp_data_d;
   logic [CNT_W-1:0]            exp_num_q, exp_num_d;
   logic                        allow_en_q, allow_en_d;
   logic [ADDR_W-1:0]           allow_adr_q, allow_adr_d;
   logic [NUM_EXP-1:0]          matched_q, matched_d;
   logic [CNT_W-1:0]            match_cnt_q, match_cnt_d;
   logic [TO_W-1:0]             cyc_q, cyc_d;
   fail_e                       fail_code_q, fail_code_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        pass_q, pass_d;

   logic [NUM_EXP-1:0]          adr_hit_c, data_hit_c;
   logic [IDX_W-1:0]            low_idx_c;
   logic                        low_vld_c;

   logic [CNT_W-1:0]            exp_num_eff;
   logic [NUM_EXP-1:0]          cur_mask, hit_mask, unmatched_hit;
   logic                        allowed, wr_hit;
   fail_e                       wr_code;

`ifdef MWMON_CAPTURE_EN
   logic [ADDR_W-1:0]           fail_adr_q, fail_adr_d;
   logic [DATA_W-1:0]           fail_data_q, fail_data_d;
`endif

   mwmon_match #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .NUM_EXP (NUM_EXP),
      .CNT_W   (CNT_W),
      .IDX_W   (IDX_W)
   ) u_match (
      .exp_adr    (exp_adr_q),
      .exp_data   (exp_data_q),
      .matched    (matched_q),
      .exp_num    (exp_num_q),
      .dataadr    (dataadr),
      .writedata  (writedata),
      .adr_hit_c  (adr_hit_c),
      .data_hit_c (data_hit_c),
      .low_idx_c  (low_idx_c),
      .low_vld_c  (low_vld_c)
   );

   // Clamp the programmed entry count into 1..NUM_EXP.
   always_comb begin
      exp_num_eff = exp_num;
      if (exp_num == '0) begin
         exp_num_eff = CNT_W'(1);
      end else if (exp_num > CNT_W'(NUM_EXP)) begin
         exp_num_eff = CNT_W'(NUM_EXP);
      end
   end

   // Next-state, write classification and output-register inputs.
   always_comb begin
      state_d     = state_q;
      exp_adr_d   = exp_adr_q;
      exp_data_d  = exp_data_q;
      exp_num_d   = exp_num_q;
      allow_en_d  = allow_en_q;
      allow_adr_d = allow_adr_q;
      matched_d   = matched_q;
      match_cnt_d = match_cnt_q;
      cyc_d       = cyc_q;
      fail_code_d = fail_code_q;
`ifdef MWMON_CAPTURE_EN
      fail_adr_d  = fail_adr_q;
      fail_data_d = fail_data_q;
`endif
      wr_code       = NONE;
      wr_hit        = 1'b0;
      hit_mask      = '0;
      allowed       = allow_en_q && (dataadr == allow_adr_q);
      cur_mask      = NUM_EXP'(1) << match_cnt_q;
      unmatched_hit = adr_hit_c & ~matched_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = RUN;
               exp_adr_d   = exp_adr;
               exp_data_d  = exp_data;
               exp_num_d   = exp_num_eff;
               allow_en_d  = allow_en;
               allow_adr_d = allow_adr;
               matched_d   = '0;
               match_cnt_d = '0;
               cyc_d       = '0;
               fail_code_d = NONE;
            end
         end
         RUN: begin
            if (cyc_q != TO_W'(TIMEOUT_CYCLES)) begin
               cyc_d = cyc_q + TO_W'(1);
            end
            if (memwrite && !allowed) begin
               if (ORDERED != 0) begin
                  // Matched entries are exactly those below the current index.
                  if ((adr_hit_c & cur_mask) != '0) begin
                     if ((data_hit_c & cur_mask) != '0) begin
                        wr_hit   = 1'b1;
                        hit_mask = cur_mask;
                     end else begin
                        wr_code = DATA_MISMATCH;
                     end
                  end else if ((unmatched_hit & ~cur_mask) != '0) begin
                     wr_code = ORDER;
                  end else if ((adr_hit_c & matched_q) != '0) begin
                     wr_code = DUPLICATE;
                  end else begin
                     wr_code = UNEXPECTED;
                  end
               end else begin
                  if (low_vld_c) begin
                     wr_hit   = 1'b1;
                     hit_mask = NUM_EXP'(1) << low_idx_c;
                  end else if (unmatched_hit != '0) begin
                     wr_code = DATA_MISMATCH;
                  end else if (adr_hit_c != '0) begin
                     wr_code = DUPLICATE;
                  end else begin
                     wr_code = UNEXPECTED;
                  end
               end
            end
            if (wr_hit) begin
               matched_d   = matched_q | hit_mask;
               match_cnt_d = match_cnt_q + CNT_W'(1);
            end
            // Failing write beats completion, completion beats timeout.
            if (wr_code != NONE) begin
               state_d     = FAIL;
               fail_code_d = wr_code;
`ifdef MWMON_CAPTURE_EN
               fail_adr_d  = dataadr;
               fail_data_d = writedata;
`endif
            end else if (wr_hit && (match_cnt_d == exp_num_q)) begin
               state_d = PASS;
            end else if (TO_EN && (cyc_q == TO_W'(TO_LAST))) begin
               state_d     = FAIL;
               fail_code_d = TIMEOUT;
`ifdef MWMON_CAPTURE_EN
               fail_adr_d  = '0;
               fail_data_d = '0;
`endif
            end
         end
         PASS, FAIL: begin
            if (clear) begin
               state_d     = IDLE;
               matched_d   = '0;
               match_cnt_d = '0;
               cyc_d       = '0;
               fail_code_d = NONE;
`ifdef MWMON_CAPTURE_EN
               fail_adr_d  = '0;
               fail_data_d = '0;
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == PASS) || (state_d == FAIL);
      pass_d = (state_d == PASS);
   end

   // State, table and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         exp_adr_q   <= '0;
         exp_data_q  <= '0;
         exp_num_q   <= '0;
         allow_en_q  <= 1'b0;
         allow_adr_q <= '0;
         matched_q   <= '0;
         match_cnt_q <= '0;
         cyc_q       <= '0;
         fail_code_q <= NONE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         exp_adr_q   <= exp_adr_d;
         exp_data_q  <= exp_data_d;
         exp_num_q   <= exp_num_d;
         allow_en_q  <= allow_en_d;
         allow_adr_q <= allow_adr_d;
         matched_q   <= matched_d;
         match_cnt_q <= match_cnt_d;
         cyc_q       <= cyc_d;
         fail_code_q <= fail_code_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
      end
   end

`ifdef MWMON_CAPTURE_EN
   // Offending-write capture registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fail_adr_q  <= '0;
         fail_data_q <= '0;
      end else begin
         fail_adr_q  <= fail_adr_d;
         fail_data_q <= fail_data_d;
      end
   end

   assign fail_adr  = fail_adr_q;
   assign fail_data = fail_data_q;
`else
   assign fail_adr  = '0;
   assign fail_data = '0;
`endif

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_code = fail_code_q;
   assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Scoreboard bench: ordered and unordered monitors see the same write stream.
module tb_mem_write_monitor;

   localparam int unsigned NE = 4;
   localparam int unsigned TO = 20;

   typedef struct packed {
      logic        pass;
      logic [2:0]  code;
      logic [2:0]  mcnt;
      logic [31:0] fadr;
      logic [31:0] fdata;
      logic [31:0] k;
   } exp_t;

   typedef struct packed {
      logic        v;
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              start, clear;
   logic [NE*32-1:0]  exp_adr, exp_data;
   logic [2:0]        exp_num;
   logic              allow_en;
   logic [31:0]       allow_adr;
   logic              memwrite;
   logic [31:0]       dataadr, writedata;

   logic              busy_o, done_o, pass_o, busy_u, done_u, pass_u;
   logic [2:0]        code_o, code_u, mcnt_o, mcnt_u;
   logic [31:0]       fadr_o, fdata_o, fadr_u, fdata_u;

   int unsigned       cyc = 0;
   int unsigned       start_cyc = 0;
   int                checks = 0;
   int                errors = 0;

   logic [31:0]       ta [NE];
   logic [31:0]       td [NE];
   int                tn;
   logic              al_en;
   logic [31:0]       al_adr;
   wr_t               wq [$];
   exp_t              q_o [$];
   exp_t              q_u [$];

   mem_write_monitor #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(NE), .ORDERED(1), .TIMEOUT_CYCLES(TO)) u_ord (
      .clk(clk), .reset(reset), .start(start), .clear(clear),
      .exp_adr(exp_adr), .exp_data(exp_data), .exp_num(exp_num),
      .allow_en(allow_en), .allow_adr(allow_adr),
      .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
      .busy(busy_o), .done(done_o), .pass(pass_o), .fail_code(code_o),
      .match_cnt(mcnt_o), .fail_adr(fadr_o), .fail_data(fdata_o));

   mem_write_monitor #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(NE), .ORDERED(0), .TIMEOUT_CYCLES(TO)) u_unord (
      .clk(clk), .reset(reset), .start(start), .clear(clear),
      .exp_adr(exp_adr), .exp_data(exp_data), .exp_num(exp_num),
      .allow_en(allow_en), .allow_adr(allow_adr),
      .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
      .busy(busy_u), .done(done_u), .pass(pass_u), .fail_code(code_u),
      .match_cnt(mcnt_u), .fail_adr(fadr_u), .fail_data(fdata_u));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Whole-run outcome derived from the classification rules, one write per cycle.
   function automatic exp_t model(input bit ord);
      exp_t        e;
      bit          m [NE];
      int          mc, nn, lo;
      bit          fin, later, earlier, any_un, any_m;
      logic [31:0] a, d;
      logic [2:0]  c;
      e   = '0;
      mc  = 0;
      fin = 1'b0;
      a   = '0;
      d   = '0;
      nn  = (tn == 0) ? 1 : tn;
      for (int j = 0; j < NE; j++) m[j] = 1'b0;
      for (int k = 1; k <= int'(TO); k++) begin
         if (!fin) begin
            c = 3'd0;
            if (k <= wq.size()) begin
               a = wq[k-1].a;
               d = wq[k-1].d;
               if (wq[k-1].v && !(al_en && a == al_adr)) begin
                  if (ord) begin
                     if (a == ta[mc]) begin
                        if (d == td[mc]) mc++;
                        else c = 3'd2;
                     end else begin
                        later = 1'b0;
                        earlier = 1'b0;
                        for (int j = 0; j < nn; j++) begin
                           if (ta[j] == a && j > mc) later = 1'b1;
                           if (ta[j] == a && j < mc) earlier = 1'b1;
                        end
                        c = later ? 3'd3 : (earlier ? 3'd4 : 3'd1);
                     end
                  end else begin
                     lo = -1;
                     for (int j = nn - 1; j >= 0; j--)
                        if (!m[j] && ta[j] == a && td[j] == d) lo = j;
                     if (lo >= 0) begin
                        m[lo] = 1'b1;
                        mc++;
                     end else begin
                        any_un = 1'b0;
                        any_m  = 1'b0;
                        for (int j = 0; j < nn; j++) begin
                           if (ta[j] == a && m[j])  any_m  = 1'b1;
                           if (ta[j] == a && !m[j]) any_un = 1'b1;
                        end
                        c = any_un ? 3'd2 : (any_m ? 3'd4 : 3'd1);
                     end
                  end
               end
            end
            if (c != 3'd0) begin
               fin = 1'b1;
               e.code = c;
               e.k = 32'(k);
               e.mcnt = 3'(mc);
`ifdef MWMON_CAPTURE_EN
               e.fadr = a;
               e.fdata = d;
`endif
            end else if (mc == nn) begin
               fin = 1'b1;
               e.pass = 1'b1;
               e.k = 32'(k);
               e.mcnt = 3'(mc);
            end else if (k == int'(TO)) begin
               fin = 1'b1;
               e.code = 3'd5;
               e.k = 32'(k);
               e.mcnt = 3'(mc);
            end
         end
      end
      return e;
   endfunction

   task automatic cmp_out(input string nm, input exp_t e, input logic p, input logic [2:0] c,
                          input logic [2:0] m, input logic [31:0] fa, input logic [31:0] fd);
      chk_eq({nm, "_pass"}, 32'(p), 32'(e.pass));
      chk_eq({nm, "_fail_code"}, 32'(c), 32'(e.code));
      chk_eq({nm, "_match_cnt"}, 32'(m), 32'(e.mcnt));
      chk_eq({nm, "_fail_adr"}, fa, e.fadr);
      chk_eq({nm, "_fail_data"}, fd, e.fdata);
      chk_eq({nm, "_latency"}, 32'(cyc - start_cyc), e.k);
   endtask

   // Pops an expectation whenever a monitor newly reports done.
   task automatic monitor();
      logic po = 1'b0;
      logic pu = 1'b0;
      forever begin
         @(negedge clk);
         if (done_o && !po) begin
            if (q_o.size() == 0) chk_eq("ord_done_without_expectation", 32'(q_o.size()), 32'd1);
            else cmp_out("ord", q_o.pop_front(), pass_o, code_o, mcnt_o, fadr_o, fdata_o);
         end
         if (done_u && !pu) begin
            if (q_u.size() == 0) chk_eq("unord_done_without_expectation", 32'(q_u.size()), 32'd1);
            else cmp_out("unord", q_u.pop_front(), pass_u, code_u, mcnt_u, fadr_u, fdata_u);
         end
         po = done_o;
         pu = done_u;
      end
   endtask

   task automatic chk_idle(input string nm);
      chk_eq({nm, "_busy"}, 32'({busy_o, busy_u}), 32'd0);
      chk_eq({nm, "_done"}, 32'({done_o, done_u}), 32'd0);
      chk_eq({nm, "_pass"}, 32'({pass_o, pass_u}), 32'd0);
      chk_eq({nm, "_fail_code"}, 32'({code_o, code_u}), 32'd0);
      chk_eq({nm, "_match_cnt"}, 32'({mcnt_o, mcnt_u}), 32'd0);
      chk_eq({nm, "_fail_adr"}, fadr_o | fadr_u, 32'd0);
      chk_eq({nm, "_fail_data"}, fdata_o | fdata_u, 32'd0);
   endtask

   task automatic load_tables();
      for (int i = 0; i < int'(NE); i++) begin
         exp_adr[i*32 +: 32]  = ta[i];
         exp_data[i*32 +: 32] = td[i];
      end
      exp_num   = 3'(tn);
      allow_en  = al_en;
      allow_adr = al_adr;
   endtask

   task automatic add_wr(input logic v, input logic [31:0] a, input logic [31:0] d);
      wr_t w;
      w.v = v;
      w.a = a;
      w.d = d;
      wq.push_back(w);
   endtask

   task automatic run_case(input bit stray);
      bit ok;
      q_o.push_back(model(1'b1));
      q_u.push_back(model(1'b0));
      load_tables();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      start_cyc = cyc;
      chk_eq("busy_after_start", 32'({busy_o, busy_u}), 32'h3);
      // Tables are latched: scribble the live inputs.
      exp_adr  = {$urandom, $urandom, $urandom, $urandom};
      exp_data = {$urandom, $urandom, $urandom, $urandom};
      exp_num  = 3'($urandom_range(0, 4));
      allow_en = 1'b0;
      for (int k = 0; k < wq.size(); k++) begin
         memwrite  = wq[k].v;
         dataadr   = wq[k].a;
         writedata = wq[k].d;
         // start/clear while both still run must be ignored.
         ok    = stray && busy_o && busy_u && ($urandom_range(0, 5) == 0);
         start = ok;
         clear = ok;
         @(negedge clk);
         start = 1'b0;
         clear = 1'b0;
      end
      memwrite = 1'b0;
      for (int t = 0; t < 40; t++) begin
         if (done_o && done_u) break;
         @(negedge clk);
      end
      chk_eq("both_done_within_bound", 32'({done_o, done_u}), 32'h3);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk_idle("after_clear");
   endtask

   task automatic set_tab(input int n, input logic [31:0] a0, input logic [31:0] d0,
                          input logic [31:0] a1, input logic [31:0] d1);
      tn = n;
      ta[0] = a0; td[0] = d0;
      ta[1] = a1; td[1] = d1;
      ta[2] = 32'h5000; td[2] = 32'h1;
      ta[3] = 32'h6000; td[3] = 32'h2;
      al_en = 1'b0;
      al_adr = 32'h0;
      wq.delete();
   endtask

   task automatic gen_random();
      int nn, len, nxt, r, j, tmp;
      int ord [NE];
      tn = $urandom_range(0, 4);
      nn = (tn == 0) ? 1 : tn;
      for (int i = 0; i < int'(NE); i++) begin
         ta[i]  = 32'h100 + 32'(4 * $urandom_range(0, 5));
         td[i]  = 32'($urandom_range(0, 3));
         ord[i] = i;
      end
      al_en  = 1'($urandom_range(0, 1));
      al_adr = 32'h100 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
         for (int i = 0; i < nn; i++) begin
            j = $urandom_range(0, nn - 1);
            tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
         end
      end
      wq.delete();
      nxt = 0;
      len = $urandom_range(nn, 16);
      for (int s = 0; s < len; s++) begin
         r = $urandom_range(0, 11);
         if (r < 7 && nxt < nn) begin
            add_wr(1'b1, ta[ord[nxt]], td[ord[nxt]]);
            nxt++;
         end else if (r == 7) add_wr(1'b0, 32'($urandom), 32'($urandom));
         else if (r == 8) add_wr(1'b1, al_adr, 32'($urandom_range(0, 3)));
         else if (r == 9) add_wr(1'b1, 32'h100 + 32'(4 * $urandom_range(0, 7)), 32'($urandom_range(0, 3)));
         else if (r == 10) add_wr(1'b1, ta[ord[0]], td[ord[0]] ^ 32'h1);
         else add_wr(1'b0, 32'h0, 32'h0);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0; clear = 1'b0;
      exp_adr = '0; exp_data = '0; exp_num = '0;
      allow_en = 1'b0; allow_adr = '0;
      memwrite = 1'b0; dataadr = '0; writedata = '0;
      fork monitor(); join_none
      repeat (3) @(negedge clk);
      chk_idle("reset");
      reset = 1'b0;
      @(negedge clk);

      // Benign address ignored, single expectation completes on the third write.
      set_tab(1, 32'd84, 32'd7, 32'd0, 32'd0);
      al_en = 1'b1; al_adr = 32'd80;
      add_wr(1'b1, 32'd80, 32'd3); add_wr(1'b1, 32'd80, 32'd5); add_wr(1'b1, 32'd84, 32'd7);
      run_case(1'b0);
      // Out-of-order: ordered fails ORDER, unordered times out.
      set_tab(2, 32'h10, 32'd1, 32'h14, 32'd2);
      add_wr(1'b1, 32'h14, 32'd2);
      run_case(1'b0);
      set_tab(2, 32'h10, 32'd1, 32'h14, 32'd2);
      add_wr(1'b1, 32'h14, 32'd2); add_wr(1'b1, 32'h10, 32'd1);
      run_case(1'b0);
      set_tab(2, 32'h10, 32'd1, 32'h14, 32'd2);
      add_wr(1'b1, 32'h14, 32'd2); add_wr(1'b1, 32'h14, 32'd2);
      run_case(1'b0);
      set_tab(1, 32'd84, 32'd7, 32'd0, 32'd0);
      add_wr(1'b1, 32'd84, 32'd6);
      run_case(1'b0);
      set_tab(1, 32'd84, 32'd7, 32'd0, 32'd0);
      add_wr(1'b1, 32'd88, 32'd7);
      run_case(1'b0);
      // No writes: timeout; then completion exactly on the timeout cycle; exp_num 0 acts as 1.
      set_tab(2, 32'h10, 32'd1, 32'h14, 32'd2);
      run_case(1'b0);
      set_tab(0, 32'd84, 32'd7, 32'h30, 32'd9);
      for (int i = 0; i < 19; i++) add_wr(1'b0, 32'h0, 32'h0);
      add_wr(1'b1, 32'd84, 32'd7);
      run_case(1'b0);

      // Asynchronous reset in the middle of a run, then a clean rerun.
      set_tab(2, 32'h10, 32'd1, 32'h14, 32'd2);
      load_tables();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      memwrite = 1'b1; dataadr = 32'h10; writedata = 32'd1;
      @(negedge clk);
      memwrite = 1'b0;
      chk_eq("mid_run_match_cnt", 32'({mcnt_o, mcnt_u}), 32'h9);
      #2 reset = 1'b1;
      #1 chk_idle("async_reset");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      add_wr(1'b1, 32'h10, 32'd1); add_wr(1'b1, 32'h14, 32'd2);
      run_case(1'b0);

      for (int n = 0; n < 60; n++) begin
         gen_random();
         run_case(1'b1);
      end

      repeat (2) @(negedge clk);
      chk_eq("scoreboard_drained", 32'(q_o.size() + q_u.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_write_monitor.md
Name: mem_write_monitor

Overview:
- Synthesizable, parametrised self-check monitor on the CPU data-memory write port (memwrite/dataadr/writedata).
- Checks a programmed list of NUM_EXP expected (address, data) writes, in ordered or unordered mode, with one benign address and a cycle timeout.
- Reports pass/fail plus a fail code.
- Sits beside top in simulation or FPGA bring-up and replaces per-program hand-written write checks.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NUM_EXP, 4, number of expected writes (1..16)
- ORDERED, 1, 1 = expectations must match in index order; 0 = any order
- TIMEOUT_CYCLES, 1000, cycles from start to fail if incomplete; 0 disables timeout

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; latches tables, IDLE->RUN
- clear  in  1  pulse; PASS/FAIL->IDLE
- exp_adr  in  NUM_EXP*ADDR_W  flattened expected addresses, entry i at [i*ADDR_W +: ADDR_W]
- exp_data  in  NUM_EXP*DATA_W  flattened expected data
- exp_num  in  $clog2(NUM_EXP+1)  active entries (1..NUM_EXP); 0 treated as 1
- allow_en  in  1  enable benign address
- allow_adr  in  ADDR_W  write address always ignored
- memwrite  in  1  write strobe, sampled posedge clk
- dataadr  in  ADDR_W  write address
- writedata  in  DATA_W  write data
- busy  out  1  state==RUN
- done  out  1  state is PASS or FAIL
- pass  out  1  state==PASS
- fail_code  out  3  mwmon_pkg::fail_e
- match_cnt  out  $clog2(NUM_EXP+1)  expectations satisfied
- fail_adr  out  ADDR_W  address of failing write (see Optional Feature)
- fail_data  out  DATA_W  data of failing write

Behaviour:
- Reset: asynchronous, active-high; state=IDLE, all outputs 0, match bitmap/index/cycle counter 0. Reset mid-RUN aborts with no report.
- States IDLE, RUN, PASS, FAIL:
  - IDLE: start -> RUN. Same edge: exp_adr/exp_data/exp_num/allow_* latched into registers, counters cleared. memwrite ignored.
  - RUN: one write evaluated per cycle when memwrite=1; cycle counter increments, saturating at TIMEOUT_CYCLES.
  - PASS/FAIL: hold all outputs; writes ignored; clear -> IDLE (outputs cleared).
  - start outside IDLE is ignored. clear in IDLE/RUN is ignored.
- Write classification, first applicable rule wins:
  1. allow_en && dataadr==allow_adr -> ignored, even if also an expected address.
  2. ORDERED=1:
     - dataadr==exp_adr[idx] && writedata==exp_data[idx] -> idx++, match_cnt++.
     - Address matches, data differs -> FAIL, DATA_MISMATCH.
     - dataadr equals a later unmatched entry -> FAIL, ORDER.
     - dataadr equals an already-matched entry -> FAIL, DUPLICATE.
  3. ORDERED=0:
     - Lowest unmatched entry j with address and data equal -> set bit j, match_cnt++.
     - Address matches only already-matched entries -> FAIL, DUPLICATE.
     - Address matches an unmatched entry with data wrong -> FAIL, DATA_MISMATCH.
  4. Otherwise -> FAIL, UNEXPECTED.
- Completion: match_cnt reaching exp_num -> PASS on the next edge, same cycle as the registered match.
- Timeout: TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES while in RUN -> FAIL, TIMEOUT.
  - A completing write on that same edge takes priority: PASS.
  - A failing write on that same edge takes priority over TIMEOUT.
- Latency: write at edge n is reflected in outputs after edge n (registered outputs, no combinational path from memwrite).
- fail_code values: NONE=0, UNEXPECTED=1, DATA_MISMATCH=2, ORDER=3, DUPLICATE=4, TIMEOUT=5. On TIMEOUT, fail_adr/fail_data=0.

Optional Feature:
- MWMON_CAPTURE_EN defined: on the FAIL transition, fail_adr/fail_data register the offending dataadr/writedata and hold until clear/reset.
- Not defined: fail_adr/fail_data tied to 0 and capture registers are not built.
- All other behaviour is identical in both builds.

Decomposition:
- mwmon_pkg holds:
  - state_e enum (IDLE, RUN, PASS, FAIL)
  - fail_e enum, 3-bit, values above
  - FAIL_CODE_W=3
- Sub-module mwmon_match: combinational. Inputs: latched tables, match bitmap, exp_num, dataadr, writedata. Outputs: per-entry adr_hit/data_hit vectors and the lowest-unmatched-hit index. Top module holds the FSM, counters and output registers.

Test Plan:
- NUM_EXP=1, exp (84,7), allow_adr=80: writes (80,3),(80,5),(84,7) -> pass=1, match_cnt=1, fail_code=0 one cycle after the third write.
- ORDERED=1, exp {(0x10,1),(0x14,2)}: write (0x14,2) first -> FAIL, fail_code=3; with MWMON_CAPTURE_EN, fail_adr=0x14, fail_data=2.
- ORDERED=0, same table: writes (0x14,2),(0x10,1) -> PASS; then rerun after clear and write (0x14,2) twice -> FAIL, fail_code=4.
- Data mismatch: exp (84,7), write (84,6) -> FAIL, fail_code=2. Write (88,7) instead -> fail_code=1.
- TIMEOUT_CYCLES=20, no writes after start -> FAIL, fail_code=5 exactly 20 cycles after start. Also: completing write on the 20th cycle -> PASS.
- Reset asserted mid-RUN after one match -> all outputs 0 immediately (asynchronous); start again -> clean rerun passes.
